// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control unit for the 8-bit lab CPU datapath.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       _CLK,
  input  logic       RESET,
  input  logic       run,
  input  logic       step,
  input  logic [7:0] instr_in,
  input  logic       mem_ack,
  output logic [7:0] ir,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       reg_we,
  output logic       reg_wsel,
  output logic [1:0] reg_dst,
  output logic       alu_b_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic [2:0] state,
  output logic [7:0] instr_count,
  output logic       err
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6;
  localparam logic [1:0] OP_ADD = 2'b00, OP_LW = 2'b01, OP_SW = 2'b10, OP_J = 2'b11;
  logic [2:0] state_q, state_d;
  logic [7:0] ir_q, ir_d, cnt_q, cnt_d;
  logic [3:0] tmo_q, tmo_d;
  logic       err_q, err_d, step_q, step_d;
  logic [1:0] op;
  logic       retire, step_rise;
  assign op        = ir_q[7:6];
  assign step_rise = step && !step_q;
  assign retire    = (state_q == EXEC && op == OP_J) ||
                     (state_q == MEM && mem_ack && op == OP_SW) || state_q == WB;
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    step_d  = step;
    case (state_q)
      IDLE:   state_d = (run || step_rise) ? FETCH : IDLE;
      FETCH:  begin
        ir_d    = instr_in;
        state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC:   begin
        state_d = (op == OP_ADD) ? WB : MEM;
        tmo_d   = 4'd0;
      end
      MEM:    begin
        // an ack in the last allowed cycle takes priority over the timeout
        if (mem_ack) state_d = (op == OP_LW) ? WB : MEM;
        else if (tmo_q == 4'(MEM_TIMEOUT - 1)) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else tmo_d = tmo_q + 4'd1;
      end
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (retire) begin
      state_d = run ? FETCH : IDLE;
      cnt_d   = cnt_q + 8'd1;
    end
  end
  always_ff @(posedge _CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      ir_q    <= 8'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      tmo_q   <= 4'd0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      step_q  <= step_d;
    end
  end
  assign pc_we       = retire;
  assign pc_sel      = retire && op == OP_J;
  assign reg_we      = state_q == WB;
  assign reg_wsel    = state_q == WB && op == OP_LW;
  assign reg_dst     = (state_q != WB) ? 2'b00 : (op == OP_LW) ? ir_q[3:2] : ir_q[1:0];
  assign alu_b_sel   = op == OP_LW || op == OP_SW;
  assign mem_req     = state_q == MEM;
  assign mem_we      = state_q == MEM && op == OP_SW;
  assign ir          = ir_q;
  assign state       = state_q;
  assign instr_count = cnt_q;
  assign err         = err_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed scoreboard bench for cpu_sequencer.
module tb_cpu_sequencer;
  logic       clk = 1'b0, rst_n, run, step, mem_ack;
  logic [7:0] instr_in, ir, instr_count;
  logic       pc_we, pc_sel, reg_we, reg_wsel, alu_b_sel, mem_req, mem_we, err;
  logic [1:0] reg_dst;
  logic [2:0] state;
  int         errors = 0, checks = 0;
  typedef struct {
    string       tag;
    logic [28:0] v;
  } exp_t;
  exp_t sb[$];
  // strobe fields: {pc_we, pc_sel, reg_we, reg_wsel, reg_dst, alu_b_sel, mem_req, mem_we}
  localparam logic [8:0] S0 = 9'b000000000, SALU = 9'b000000100, SMEM = 9'b000000110,
                         SADD = 9'b101011000, SLW = 9'b101101100, SSW = 9'b100000111,
                         SJ = 9'b110000000;
  cpu_sequencer dut (
    ._CLK(clk), .RESET(rst_n), .run(run), .step(step), .instr_in(instr_in),
    .mem_ack(mem_ack), .ir(ir), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .reg_wsel(reg_wsel), .reg_dst(reg_dst), .alu_b_sel(alu_b_sel), .mem_req(mem_req),
    .mem_we(mem_we), .state(state), .instr_count(instr_count), .err(err)
  );
  always #5 clk = ~clk;
  task automatic cyc(input string tag, input logic [2:0] st, input logic [8:0] s,
                     input logic [7:0] cnt, input logic e, input logic [7:0] irx);
    exp_t x, y;
    logic [28:0] obs;
    x.tag = tag;
    x.v = {st, s, cnt, e, irx};
    sb.push_back(x);
    @(negedge clk);
    obs = {state, pc_we, pc_sel, reg_we, reg_wsel, reg_dst, alu_b_sel, mem_req, mem_we,
           instr_count, err, ir};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      y = sb.pop_front();
      assert (obs === y.v) else begin
        errors++;
        $error("FAIL %s: got st=%0d strb=%b cnt=%0d err=%b ir=%h, expected st=%0d strb=%b cnt=%0d err=%b ir=%h",
               y.tag, obs[28:26], obs[25:17], obs[16:9], obs[8], obs[7:0],
               y.v[28:26], y.v[25:17], y.v[16:9], y.v[8], y.v[7:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; run = 1'b1; step = 1'b0; mem_ack = 1'b0; instr_in = 8'h1B;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 3'd0, S0, 8'd0, 1'b0, 8'h00);
    rst_n = 1'b1;
    cyc("idle_run", 3'd0, S0, 8'd0, 1'b0, 8'h00);
    cyc("add_fetch", 3'd1, S0, 8'd0, 1'b0, 8'h00);
    cyc("add_decode", 3'd2, S0, 8'd0, 1'b0, 8'h1B);
    cyc("add_exec", 3'd3, S0, 8'd0, 1'b0, 8'h1B);
    cyc("add_wb", 3'd5, SADD, 8'd0, 1'b0, 8'h1B);
    instr_in = 8'h46;
    cyc("lw_fetch", 3'd1, S0, 8'd1, 1'b0, 8'h1B);
    cyc("lw_decode", 3'd2, SALU, 8'd1, 1'b0, 8'h46);
    cyc("lw_exec", 3'd3, SALU, 8'd1, 1'b0, 8'h46);
    cyc("lw_mem1", 3'd4, SMEM, 8'd1, 1'b0, 8'h46);
    cyc("lw_mem2", 3'd4, SMEM, 8'd1, 1'b0, 8'h46);
    mem_ack = 1'b1;
    cyc("lw_mem3_ack", 3'd4, SMEM, 8'd1, 1'b0, 8'h46);
    mem_ack = 1'b0;
    cyc("lw_wb", 3'd5, SLW, 8'd1, 1'b0, 8'h46);
    instr_in = 8'h87;
    cyc("sw_fetch", 3'd1, SALU, 8'd2, 1'b0, 8'h46);
    cyc("sw_decode", 3'd2, SALU, 8'd2, 1'b0, 8'h87);
    cyc("sw_exec", 3'd3, SALU, 8'd2, 1'b0, 8'h87);
    mem_ack = 1'b1;
    cyc("sw_mem_ack", 3'd4, SSW, 8'd2, 1'b0, 8'h87);
    mem_ack = 1'b0;
    instr_in = 8'hFE;
    cyc("j_fetch", 3'd1, SALU, 8'd3, 1'b0, 8'h87);
    cyc("j_decode", 3'd2, S0, 8'd3, 1'b0, 8'hFE);
    run = 1'b0;
    cyc("j_exec", 3'd3, SJ, 8'd3, 1'b0, 8'hFE);
    cyc("run_drop_idle", 3'd0, S0, 8'd4, 1'b0, 8'hFE);
    instr_in = 8'h1B;
    step = 1'b1;
    cyc("step_idle", 3'd0, S0, 8'd4, 1'b0, 8'hFE);
    cyc("step_fetch", 3'd1, S0, 8'd4, 1'b0, 8'hFE);
    cyc("step_decode", 3'd2, S0, 8'd4, 1'b0, 8'h1B);
    cyc("step_exec", 3'd3, S0, 8'd4, 1'b0, 8'h1B);
    cyc("step_wb", 3'd5, SADD, 8'd4, 1'b0, 8'h1B);
    for (int i = 0; i < 5; i++) cyc("step_held", 3'd0, S0, 8'd5, 1'b0, 8'h1B);
    step = 1'b0;
    cyc("step_low", 3'd0, S0, 8'd5, 1'b0, 8'h1B);
    step = 1'b1;
    cyc("step2_idle", 3'd0, S0, 8'd5, 1'b0, 8'h1B);
    cyc("step2_fetch", 3'd1, S0, 8'd5, 1'b0, 8'h1B);
    cyc("step2_decode", 3'd2, S0, 8'd5, 1'b0, 8'h1B);
    cyc("step2_exec", 3'd3, S0, 8'd5, 1'b0, 8'h1B);
    cyc("step2_wb", 3'd5, SADD, 8'd5, 1'b0, 8'h1B);
    step = 1'b0;
    cyc("step2_done", 3'd0, S0, 8'd6, 1'b0, 8'h1B);
    run = 1'b1;
    instr_in = 8'h46;
    cyc("late_idle", 3'd0, S0, 8'd6, 1'b0, 8'h1B);
    cyc("late_fetch", 3'd1, S0, 8'd6, 1'b0, 8'h1B);
    cyc("late_decode", 3'd2, SALU, 8'd6, 1'b0, 8'h46);
    cyc("late_exec", 3'd3, SALU, 8'd6, 1'b0, 8'h46);
    for (int i = 0; i < 14; i++) cyc("late_mem", 3'd4, SMEM, 8'd6, 1'b0, 8'h46);
    mem_ack = 1'b1;
    cyc("late_mem15_ack", 3'd4, SMEM, 8'd6, 1'b0, 8'h46);
    mem_ack = 1'b0;
    cyc("late_wb", 3'd5, SLW, 8'd6, 1'b0, 8'h46);
    cyc("to_fetch", 3'd1, SALU, 8'd7, 1'b0, 8'h46);
    cyc("to_decode", 3'd2, SALU, 8'd7, 1'b0, 8'h46);
    cyc("to_exec", 3'd3, SALU, 8'd7, 1'b0, 8'h46);
    for (int i = 0; i < 15; i++) cyc("to_mem", 3'd4, SMEM, 8'd7, 1'b0, 8'h46);
    cyc("halt", 3'd6, SALU, 8'd7, 1'b1, 8'h46);
    mem_ack = 1'b1;
    step = 1'b1;
    cyc("halt_ack_ignored", 3'd6, SALU, 8'd7, 1'b1, 8'h46);
    mem_ack = 1'b0;
    cyc("halt_sticky", 3'd6, SALU, 8'd7, 1'b1, 8'h46);
    rst_n = 1'b0;
    cyc("halt_at_reset", 3'd6, SALU, 8'd7, 1'b1, 8'h46);
    rst_n = 1'b1;
    run = 1'b0;
    step = 1'b0;
    cyc("after_reset", 3'd0, S0, 8'd0, 1'b0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
